imem_loader: RTL and testbench

Instruction-memory loader for the MIPS fetch stage: it writes the instruction memory that fetch reads, so the memory no longer has to be preloaded from a file. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. Each word is written to the instruction memory, then read back and compared. After a successful load it raises the enable that drives the fetch stage's `read_enable`.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams big-endian bytes into instruction memory, verifies each
// word by read-back, then enables the fetch stage.
`default_nettype none

module imem_loader #(
  parameter int MEM_BYTES  = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-2:0] i_word_count,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_fetch_enable,
  output logic [ADDR_WIDTH-2:0] o_words_loaded
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] c_MAX_WORDS = ADDR_WIDTH'(MEM_BYTES / 4);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_RECV   = 3'd1;
  localparam logic [2:0] c_WRITE  = 3'd2;
  localparam logic [2:0] c_VRD    = 3'd3;
  localparam logic [2:0] c_VCMP   = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;
  localparam logic [2:0] c_ERROR  = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_widx;
  logic [CW-1:0] w_widx_inc;
  logic [1:0]    r_bidx;
  logic [31:0]   r_word;
  logic          w_can_start;
  logic          w_accept;
  logic          w_match;

  assign w_can_start = i_start &&
                       (r_state == c_IDLE || r_state == c_DONE || r_state == c_ERROR);
  assign w_accept    = (r_state == c_RECV) && i_byte_valid;
  assign w_match     = (i_mem_rdata == r_word);
  assign w_widx_inc  = r_widx + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_DONE, c_ERROR: begin
        if (i_start) begin
          if (i_word_count == '0) begin
            w_next = c_DONE;
          end else if ({1'b0, i_word_count} > c_MAX_WORDS) begin
            w_next = c_ERROR;
          end else begin
            w_next = c_RECV;
          end
        end
      end
      c_RECV: begin
        if (i_byte_valid && r_bidx == 2'd3) begin
          w_next = c_WRITE;
        end
      end
      c_WRITE: w_next = c_VRD;
      c_VRD:   w_next = c_VCMP;
      c_VCMP: begin
        if (!w_match) begin
          w_next = c_ERROR;
        end else if (w_widx_inc == r_count) begin
          w_next = c_DONE;
        end else begin
          w_next = c_RECV;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  // Word index doubles as the verified-word count: it only advances on a good compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_word  <= '0;
    end else begin
      if (w_can_start) begin
        r_count <= i_word_count;
        r_widx  <= '0;
        r_bidx  <= '0;
      end
      if (w_accept) begin
        r_word <= {r_word[23:0], i_byte};
        r_bidx <= r_bidx + 2'd1;
      end
      if (r_state == c_VCMP && w_match) begin
        r_widx <= w_widx_inc;
        r_bidx <= '0;
      end
    end
  end

  always_comb begin
    o_byte_ready   = (r_state == c_RECV);
    o_mem_we       = (r_state == c_WRITE);
    o_mem_re       = (r_state == c_VRD);
    o_busy         = (r_state == c_RECV) || (r_state == c_WRITE) ||
                     (r_state == c_VRD)  || (r_state == c_VCMP);
    o_done         = (r_state == c_DONE);
    o_error        = (r_state == c_ERROR);
    o_fetch_enable = (r_state == c_DONE);
    o_mem_addr     = {r_widx[ADDR_WIDTH-3:0], 2'b00};
    o_mem_wdata    = r_word;
    o_words_loaded = r_widx;
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [5:0]  i_word_count;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [6:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic        o_fetch_enable;
  logic [5:0]  o_words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream  [0:127];
  logic [31:0] mem     [0:31];
  logic [6:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  int          wr_n = 0;
  int          rd_n = 0;
  logic        flip_en = 1'b0;
  logic [6:0]  flip_addr = 7'h0;

  imem_loader #(.MEM_BYTES(128), .ADDR_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_word_count(i_word_count),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_fetch_enable(o_fetch_enable),
    .o_words_loaded(o_words_loaded)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory model with write/read logging and optional bit-0 corruption.
  always @(posedge clk) begin
    if (o_mem_we) begin
      mem[o_mem_addr[6:2]] <= o_mem_wdata;
      wr_addr[wr_n]        <= o_mem_addr;
      wr_data[wr_n]        <= o_mem_wdata;
      wr_n                 <= wr_n + 1;
    end
    if (o_mem_re) begin
      i_mem_rdata <= mem[o_mem_addr[6:2]] ^ {31'b0, (flip_en && o_mem_addr == flip_addr)};
      rd_n        <= rd_n + 1;
    end
  end

  // Starts a session and streams nbytes; t_end is the cycle (1 = cycle after the
  // start edge) in which done or error is first seen, or -1 if the budget runs out.
  task automatic run_session(input int count, input int nbytes, input int stall_at,
                             input int stall_len, input int budget, output int t_end);
    int idx = 0;
    int stall = 0;
    t_end = -1;
    @(negedge clk);
    i_start      = 1'b1;
    i_word_count = 6'(count);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done || o_error) begin
        t_end = cyc;
        break;
      end
      if (idx < nbytes && !(idx == stall_at && stall < stall_len)) begin
        i_byte_valid = 1'b1;
        i_byte       = stream[idx];
        if (o_byte_ready) idx++;
      end else begin
        i_byte_valid = 1'b0;
        i_byte       = 8'hEE;
        if (idx == stall_at) stall++;
      end
    end
    i_byte_valid = 1'b0;
    i_start      = 1'b0;
  endtask

  task automatic load_two_words();
    logic [63:0] v;
    v = 64'h20080005_8C090004;
    for (int i = 0; i < 8; i++) stream[i] = v[63 - 8*i -: 8];
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_word_count = '0; i_byte_valid = 1'b0; i_byte = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (o_byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_byte_ready); end
    checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_mem_we); end
    checks++; if (o_mem_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", o_mem_re); end
    checks++; if (o_mem_addr !== 7'h0) begin errors++; $display("FAIL reset_addr got %h want 0", o_mem_addr); end
    checks++; if (o_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", o_mem_wdata); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", o_error); end
    checks++; if (o_fetch_enable !== 1'b0) begin errors++; $display("FAIL reset_fetch got %b want 0", o_fetch_enable); end
    checks++; if (o_words_loaded !== 6'd0) begin errors++; $display("FAIL reset_words got %0d want 0", o_words_loaded); end
    reset = 1'b0;
  endtask

  task automatic test_two_word();
    int t; int b;
    load_two_words();
    b = wr_n;
    run_session(2, 8, -1, 0, 40, t);
    checks++; if (t != 15) begin errors++; $display("FAIL two_done_cycle got %0d want 15", t); end
    checks++; if (wr_n - b != 2) begin errors++; $display("FAIL two_wr_count got %0d want 2", wr_n - b); end
    checks++; if (wr_addr[b] !== 7'h00 || wr_data[b] !== 32'h20080005) begin errors++; $display("FAIL two_w0 got %h@%h want 20080005@00", wr_data[b], wr_addr[b]); end
    checks++; if (wr_addr[b+1] !== 7'h04 || wr_data[b+1] !== 32'h8C090004) begin errors++; $display("FAIL two_w1 got %h@%h want 8c090004@04", wr_data[b+1], wr_addr[b+1]); end
    checks++; if (o_fetch_enable !== 1'b1 || o_done !== 1'b1) begin errors++; $display("FAIL two_done_fetch got %b%b want 11", o_done, o_fetch_enable); end
    checks++; if (o_words_loaded !== 6'd2) begin errors++; $display("FAIL two_words got %0d want 2", o_words_loaded); end
  endtask

  task automatic test_stall();
    int t; int b;
    load_two_words();
    b = wr_n;
    run_session(2, 8, 2, 3, 40, t);
    checks++; if (t != 18) begin errors++; $display("FAIL stall_done_cycle got %0d want 18", t); end
    checks++; if (wr_data[b] !== 32'h20080005 || wr_data[b+1] !== 32'h8C090004) begin errors++; $display("FAIL stall_data got %h %h want 20080005 8c090004", wr_data[b], wr_data[b+1]); end
    checks++; if (wr_n - b != 2) begin errors++; $display("FAIL stall_wr_count got %0d want 2", wr_n - b); end
  endtask

  task automatic test_mismatch();
    int t; int bw; int br;
    load_two_words();
    flip_en = 1'b1; flip_addr = 7'h04;
    bw = wr_n; br = rd_n;
    run_session(2, 8, -1, 0, 40, t);
    repeat (10) @(negedge clk);
    checks++; if (t != 15) begin errors++; $display("FAIL mis_error_cycle got %0d want 15", t); end
    checks++; if (o_error !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL mis_flags got err=%b done=%b want err=1 done=0", o_error, o_done); end
    checks++; if (o_fetch_enable !== 1'b0) begin errors++; $display("FAIL mis_fetch got %b want 0", o_fetch_enable); end
    checks++; if (o_words_loaded !== 6'd1) begin errors++; $display("FAIL mis_words got %0d want 1", o_words_loaded); end
    checks++; if (wr_n - bw != 2 || rd_n - br != 2) begin errors++; $display("FAIL mis_strobes got wr=%0d rd=%0d want 2 2", wr_n - bw, rd_n - br); end
    flip_en = 1'b0;
  endtask

  task automatic test_count_bounds();
    int t; int bw; int br;
    bw = wr_n; br = rd_n;
    run_session(0, 0, -1, 0, 10, t);
    checks++; if (t != 1 || o_done !== 1'b1) begin errors++; $display("FAIL cnt0_done got cycle %0d done %b want 1 1", t, o_done); end
    run_session(33, 0, -1, 0, 10, t);
    checks++; if (t != 1 || o_error !== 1'b1) begin errors++; $display("FAIL cnt33_error got cycle %0d err %b want 1 1", t, o_error); end
    checks++; if (wr_n != bw || rd_n != br) begin errors++; $display("FAIL cnt_bad_strobes got wr=%0d rd=%0d want 0 0", wr_n - bw, rd_n - br); end
    for (int k = 0; k < 32; k++) begin
      stream[4*k]   = 8'(k);
      stream[4*k+1] = 8'hA5;
      stream[4*k+2] = 8'(k) ^ 8'h3C;
      stream[4*k+3] = 8'h5A;
    end
    bw = wr_n;
    run_session(32, 128, -1, 0, 300, t);
    checks++; if (t != 225) begin errors++; $display("FAIL cnt32_done_cycle got %0d want 225", t); end
    checks++; if (wr_n - bw != 32) begin errors++; $display("FAIL cnt32_wr_count got %0d want 32", wr_n - bw); end
    checks++; if (wr_addr[bw+31] !== 7'h7C || wr_data[bw+31] !== 32'h1FA5235A) begin errors++; $display("FAIL cnt32_last got %h@%h want 1fa5235a@7c", wr_data[bw+31], wr_addr[bw+31]); end
    checks++; if (o_words_loaded !== 6'd32 || o_done !== 1'b1) begin errors++; $display("FAIL cnt32_final got words=%0d done=%b want 32 1", o_words_loaded, o_done); end
  endtask

  task automatic test_reset_mid();
    int t; int bw;
    stream[0] = 8'hDE; stream[1] = 8'hAD;
    bw = wr_n;
    run_session(1, 2, -1, 0, 4, t);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b ready=%b want 0 0", o_busy, o_byte_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_n != bw) begin errors++; $display("FAIL rmid_no_write got %0d writes want 0", wr_n - bw); end
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    run_session(1, 4, -1, 0, 20, t);
    checks++; if (t != 8) begin errors++; $display("FAIL rmid_done_cycle got %0d want 8", t); end
    checks++; if (wr_n - bw != 1 || wr_addr[bw] !== 7'h00 || wr_data[bw] !== 32'h11223344) begin errors++; $display("FAIL rmid_write got n=%0d %h@%h want 1 11223344@00", wr_n - bw, wr_data[bw], wr_addr[bw]); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_stall();
    test_mismatch();
    test_count_bounds();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
